vector_stream_out: RTL

- Downstream read sequencer for the parallel-in/serial-out vector register stage.
- On a start pulse, walks the register's read address from 0 to len-1 and samples the selected element.
- Emits the elements as a valid/ready stream with a last flag, then signals completion.
- Sits between the vector result register and the coprocessor's output stream interface.

---
 rtl/vector_stream_out.sv | 115 +++++++++++
 1 files changed

// File: rtl/vector_stream_out.sv
// Read sequencer: walks rd_addr 0..len-1 over the vector register and streams elements out.
// Latency: start at edge 0, first beat valid in cycle 2, one beat/cycle at full throughput, done one cycle after the last handshake.
// Backpressure: m_tready low stalls issue; m_tdata/m_tlast hold while m_tvalid is high and unaccepted.
module vector_stream_out #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW:0]      len,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);

    state_t      state;
    state_t      state_nxt;
    logic [AW:0] idx;
    logic [AW:0] len_q;
    logic [AW:0] len_clamp;
    logic        start_acc;
    logic        issue;
    logic        hs;
    logic        hs_last;
    logic        final_issue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        start_acc   = 1'b0;
        issue       = 1'b0;
        hs          = m_tvalid && m_tready;
        hs_last     = m_tvalid && m_tready && m_tlast;
        len_clamp   = (len > DEPTH_LEN) ? DEPTH_LEN : len;
        final_issue = (idx == (len_q - 1'b1));
        case (state)
            IDLE: begin
                start_acc = start;
                if (start && (len_clamp != '0)) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                busy  = 1'b1;
                issue = (idx < len_q) && (!m_tvalid || m_tready);
                if (hs_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done     <= 1'b0;
            rd_addr  <= '0;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            idx      <= '0;
            len_q    <= '0;
        end else begin
            done <= 1'b0;
            if (start_acc) begin
                len_q   <= len_clamp;
                idx     <= '0;
                rd_addr <= '0;
                // A zero-length request completes without entering STREAM.
                if (len_clamp == '0) begin
                    done <= 1'b1;
                end
            end
            if (issue) begin
                m_tdata  <= rd_data;
                m_tvalid <= 1'b1;
                m_tlast  <= final_issue;
                idx      <= idx + 1'b1;
                if (!final_issue) begin
                    rd_addr <= rd_addr + AW'(1);
                end
            end else if (hs) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
            end
            if (hs_last) begin
                done    <= 1'b1;
                rd_addr <= '0;
            end
        end
    end

endmodule
